// File: rtl/simon_serial_host.sv
// Host-side driver for the SIMON serial core port.
// Serialises a plaintext (and optionally a key) into the core's data_rdy
// command protocol, then collects the serial ciphertext returned under
// core_valid and presents it as a parallel word with a done pulse.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start, load_key   - request pulse (sampled in IDLE) and key-load select
//   plaintext, key    - request payload, captured on an accepted start
//   busy, done        - transaction in flight / one-cycle completion pulse
//   timeout           - sticky abort flag, cleared by the next accepted start
//   ciphertext        - last captured result
//   core_data_rdy     - command to core: 0 idle, 1 plaintext, 2 key, 3 encrypt
//   core_data_in      - serial data bit to core, LSB first
//   core_debug        - debug select, fixed to ciphertext return
//   core_cipher_out   - serial ciphertext bit from core
//   core_valid        - qualifies core_cipher_out
module simon_serial_host #(
    parameter int unsigned BLOCK_W     = 32,
    parameter int unsigned KEY_W       = 64,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_key,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic [1:0]         core_data_rdy,
    output logic               core_data_in,
    output logic               core_debug,
    input  logic               core_cipher_out,
    input  logic               core_valid
);

    localparam int unsigned MAX_AB = (BLOCK_W > KEY_W) ? BLOCK_W : KEY_W;
    localparam int unsigned MAX_N  = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int unsigned CNT_W  = $clog2(MAX_N) + 1;

    localparam logic [CNT_W-1:0] PT_LAST  = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] RDY_IDLE = 2'd0;
    localparam logic [1:0] RDY_PT   = 2'd1;
    localparam logic [1:0] RDY_KEY  = 2'd2;
    localparam logic [1:0] RDY_ENC  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_PT,
        ST_LOAD_KEY,
        ST_ENCRYPT,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] pt_shift_q, pt_shift_d;
    logic [KEY_W-1:0]   key_shift_q, key_shift_d;
    logic               lk_q, lk_d;
    logic [BLOCK_W-1:0] ct_shift_q, ct_shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [BLOCK_W-1:0] ciphertext_q, ciphertext_d;
    logic [1:0]         rdy_q, rdy_d;
    logic               data_in_q, data_in_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pt_shift_q   <= '0;
            key_shift_q  <= '0;
            lk_q         <= 1'b0;
            ct_shift_q   <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            ciphertext_q <= '0;
            rdy_q        <= RDY_IDLE;
            data_in_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pt_shift_q   <= pt_shift_d;
            key_shift_q  <= key_shift_d;
            lk_q         <= lk_d;
            ct_shift_q   <= ct_shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            ciphertext_q <= ciphertext_d;
            rdy_q        <= rdy_d;
            data_in_q    <= data_in_d;
        end
    end

    // Next state. Outputs are computed for the state being entered so that
    // the registered command and data bit line up with the registered state.
    always_comb begin
        state_d      = state_q;
        pt_shift_d   = pt_shift_q;
        key_shift_d  = key_shift_q;
        lk_d         = lk_q;
        ct_shift_d   = ct_shift_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = timeout_q;
        ciphertext_d = ciphertext_q;
        rdy_d        = RDY_IDLE;
        data_in_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pt_shift_d  = plaintext;
                    key_shift_d = key;
                    lk_d        = load_key;
                    ct_shift_d  = '0;
                    bit_cnt_d   = '0;
                    wait_cnt_d  = '0;
                    timeout_d   = 1'b0;
                    busy_d      = 1'b1;
                    rdy_d       = RDY_PT;
                    data_in_d   = plaintext[0];
                    state_d     = ST_LOAD_PT;
                end
            end

            ST_LOAD_PT: begin
                if (bit_cnt_q == PT_LAST) begin
                    bit_cnt_d = '0;
                    if (lk_q) begin
                        rdy_d     = RDY_KEY;
                        data_in_d = key_shift_q[0];
                        state_d   = ST_LOAD_KEY;
                    end else begin
                        rdy_d      = RDY_ENC;
                        wait_cnt_d = '0;
                        state_d    = ST_ENCRYPT;
                    end
                end else begin
                    bit_cnt_d  = bit_cnt_q + CNT_ONE;
                    pt_shift_d = pt_shift_q >> 1;
                    rdy_d      = RDY_PT;
                    data_in_d  = pt_shift_q[1];
                end
            end

            ST_LOAD_KEY: begin
                if (bit_cnt_q == KEY_LAST) begin
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    rdy_d      = RDY_ENC;
                    state_d    = ST_ENCRYPT;
                end else begin
                    bit_cnt_d   = bit_cnt_q + CNT_ONE;
                    key_shift_d = key_shift_q >> 1;
                    rdy_d       = RDY_KEY;
                    data_in_d   = key_shift_q[1];
                end
            end

            ST_ENCRYPT: begin
                rdy_d = RDY_ENC;
                if (core_valid) begin
                    // LSB-first return: each new bit enters at the MSB
                    ct_shift_d = {core_cipher_out, ct_shift_q[BLOCK_W-1:1]};
                    wait_cnt_d = '0;
                    if (bit_cnt_q == PT_LAST) begin
                        bit_cnt_d    = '0;
                        ciphertext_d = ct_shift_d;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        rdy_d        = RDY_IDLE;
                        state_d      = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    // Abort: keep previous ciphertext, flag and return idle
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    rdy_d      = RDY_IDLE;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign ciphertext    = ciphertext_q;
    assign core_data_rdy = rdy_q;
    assign core_data_in  = data_in_q;
    assign core_debug    = 1'b0;

endmodule

// File: tb/tb_simon_serial_host.sv
// Bench for simon_serial_host: a serial core model receives the command
// stream and returns a chosen ciphertext; expectations come from the
// protocol rules (phase lengths, latencies, bit order, timeout window).
module tb_simon_serial_host;

    localparam int unsigned BW = 32;
    localparam int unsigned KW = 64;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_key;
    logic [BW-1:0] plaintext;
    logic [KW-1:0] key;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [BW-1:0] ciphertext;
    logic [1:0]    core_data_rdy;
    logic          core_data_in;
    logic          core_debug;
    logic          core_cipher_out;
    logic          core_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [BW-1:0] last_ct;

    simon_serial_host #(
        .BLOCK_W    (BW),
        .KEY_W      (KW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .load_key       (load_key),
        .plaintext      (plaintext),
        .key            (key),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .ciphertext     (ciphertext),
        .core_data_rdy  (core_data_rdy),
        .core_data_in   (core_data_in),
        .core_debug     (core_debug),
        .core_cipher_out(core_cipher_out),
        .core_valid     (core_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request plus core model. mode: 0 valid every cycle, 1 five-cycle
    // gap after every 8 bits, 2 never valid. abort_bit >= 0 resets the DUT
    // when that key bit is on the wire.
    task automatic run_txn(input logic [BW-1:0] pt, input logic [KW-1:0] k,
                           input logic lk, input logic [BW-1:0] ct, input int mode,
                           input bit poke_pt, input bit poke_done, input bit noise,
                           input int abort_bit);
        int cyc, first1, first3, done_cyc, n1, n2, sent, gap, exp_enc;
        int prev_rdy;
        logic [BW-1:0] pt_rx;
        logic [KW-1:0] key_rx;
        bit fin, order_ok;
        cyc = 0; first1 = -1; first3 = -1; done_cyc = -1;
        n1 = 0; n2 = 0; sent = 0; gap = 0; prev_rdy = 0;
        pt_rx = '0; key_rx = '0; fin = 1'b0; order_ok = 1'b1;

        @(negedge clk);
        start = 1'b1; plaintext = pt; key = k; load_key = lk;

        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; core_valid = 1'b0; core_cipher_out = 1'b0;
            if (cyc == 1) begin
                check_eq("busy_after_start", 64'(busy), 64'(1));
                check_eq("timeout_cleared", 64'(timeout), 64'(0));
                // Inputs change after capture; the DUT must use latched copies
                plaintext = $urandom; key = {$urandom, $urandom}; load_key = 1'($urandom);
            end
            if (done) begin
                fin = 1'b1;
                done_cyc = cyc;
                check_eq("ct_at_done", 64'(ciphertext), 64'((mode == 2) ? last_ct : ct));
                check_eq("timeout_at_done", 64'(timeout), 64'((mode == 2) ? 1 : 0));
                check_eq("busy_at_done", 64'(busy), 64'(0));
                check_eq("rdy_at_done", 64'(core_data_rdy), 64'(0));
                if (poke_done) begin
                    start = 1'b1; plaintext = $urandom; load_key = 1'b0;
                end
            end else begin
                if (int'(core_data_rdy) < prev_rdy) order_ok = 1'b0;
                prev_rdy = int'(core_data_rdy);
                case (core_data_rdy)
                    2'd1: begin
                        if (first1 < 0) first1 = cyc;
                        if (n1 < int'(BW)) pt_rx[n1] = core_data_in;
                        n1++;
                        if (noise) begin
                            core_valid = 1'($urandom); core_cipher_out = 1'($urandom);
                        end
                        if (poke_pt && n1 == 5) start = 1'b1;
                    end
                    2'd2: begin
                        if (abort_bit >= 0 && n2 == abort_bit) begin
                            reset = 1'b1;
                            @(negedge clk);
                            reset = 1'b0;
                            check_eq("rst_rdy", 64'(core_data_rdy), 64'(0));
                            check_eq("rst_busy", 64'(busy), 64'(0));
                            check_eq("rst_ct", 64'(ciphertext), 64'(0));
                            check_eq("rst_done", 64'(done), 64'(0));
                            check_eq("rst_pt_rx", 64'(pt_rx), 64'(pt));
                            last_ct = '0;
                            return;
                        end
                        if (n2 < int'(KW)) key_rx[n2] = core_data_in;
                        n2++;
                        if (noise) begin
                            core_valid = 1'($urandom); core_cipher_out = 1'($urandom);
                        end
                    end
                    2'd3: begin
                        if (first3 < 0) first3 = cyc;
                        if (mode != 2 && sent < int'(BW)) begin
                            if (mode == 1 && gap > 0) begin
                                gap--;
                            end else begin
                                core_valid = 1'b1;
                                core_cipher_out = ct[sent];
                                sent++;
                                if (mode == 1 && (sent % 8) == 0) gap = 5;
                            end
                        end
                    end
                    default: order_ok = 1'b0;
                endcase
            end
        end

        check_eq("done_seen", 64'(fin), 64'(1));
        check_eq("phase_order", 64'(order_ok), 64'(1));
        check_eq("pt_bits", 64'(n1), 64'(BW));
        check_eq("pt_serial", 64'(pt_rx), 64'(pt));
        check_eq("key_bits", 64'(n2), 64'(lk ? KW : 0));
        if (lk) check_eq("key_serial", key_rx, k);
        check_eq("first_rdy1_lat", 64'(first1), 64'(1));
        check_eq("enc_start_lat", 64'(first3 - first1), 64'(BW + (lk ? KW : 0)));
        exp_enc = (mode == 2) ? int'(TO) : ((mode == 1) ? int'(BW) + 5 * ((int'(BW) - 1) / 8) : int'(BW));
        check_eq("done_lat", 64'(done_cyc - first3), 64'(exp_enc));

        @(negedge clk);
        start = 1'b0;
        check_eq("done_width", 64'(done), 64'(0));
        check_eq("busy_after_done", 64'(busy), 64'(0));
        check_eq("rdy_after_done", 64'(core_data_rdy), 64'(0));
        check_eq("timeout_sticky", 64'(timeout), 64'((mode == 2) ? 1 : 0));
        if (poke_done) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_eq("start_in_done_ignored", 64'(busy), 64'(0));
                check_eq("no_extra_done", 64'(done), 64'(0));
            end
        end
        if (mode != 2) last_ct = ct;
    endtask

    localparam logic [KW-1:0] VK  = 64'h1918111009080100;
    localparam logic [BW-1:0] VPT = 32'h65656877;
    localparam logic [BW-1:0] VCT = 32'hc69be9bb;

    initial begin
        reset = 1'b1; start = 1'b0; load_key = 1'b0; plaintext = '0; key = '0;
        core_cipher_out = 1'b0; core_valid = 1'b0; last_ct = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy0", 64'(busy), 64'(0));
        check_eq("rst_done0", 64'(done), 64'(0));
        check_eq("rst_timeout0", 64'(timeout), 64'(0));
        check_eq("rst_ct0", 64'(ciphertext), 64'(0));
        check_eq("rst_rdy0", 64'(core_data_rdy), 64'(0));
        check_eq("rst_din0", 64'(core_data_in), 64'(0));
        check_eq("rst_debug0", 64'(core_debug), 64'(0));

        run_txn(VPT, VK, 1'b1, VCT, 0, 1'b0, 1'b0, 1'b0, -1);
        run_txn(VPT, VK, 1'b0, VCT, 0, 1'b0, 1'b0, 1'b0, -1);
        run_txn(VPT, VK, 1'b1, VCT, 1, 1'b0, 1'b0, 1'b0, -1);
        run_txn(VPT, VK, 1'b0, VCT, 2, 1'b0, 1'b0, 1'b0, -1);
        run_txn(32'h0badf00d, VK, 1'b0, 32'h13572468, 0, 1'b0, 1'b0, 1'b0, -1);
        run_txn(VPT, VK, 1'b1, VCT, 0, 1'b0, 1'b0, 1'b0, 20);
        run_txn(VPT, VK, 1'b1, VCT, 0, 1'b0, 1'b0, 1'b0, -1);
        run_txn(VPT, VK, 1'b0, VCT, 0, 1'b1, 1'b1, 1'b0, -1);

        for (int t = 0; t < 10; t++) begin
            run_txn($urandom, {$urandom, $urandom}, 1'($urandom), $urandom,
                    int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simon_serial_host.md
Name: simon_serial_host

Overview:
- Host-side driver for the SIMON serial core interface. Converts a parallel plaintext/key request into the core's serial command protocol: data_rdy codes 1/2/3, one data bit per cycle.
- Collects the serial ciphertext returned under valid and presents it as a parallel word with a done pulse.
- Sits between a bus/test harness and simon_module, on the opposite side of its serial port.

Parameters:
- BLOCK_W, 32, plaintext/ciphertext width in bits.
- KEY_W, 64, key width in bits.
- TIMEOUT_CYC, 1024, maximum cycles to wait for the next valid bit before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- load_key  in  1  sampled with start; 1 = send key phase, 0 = reuse key already in core.
- plaintext  in  BLOCK_W  captured on accepted start.
- key  in  KEY_W  captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when ciphertext is updated or a timeout occurs.
- timeout  out  1  sticky error flag; cleared on the next accepted start.
- ciphertext  out  BLOCK_W  last captured result.
- core_data_rdy  out  2  command to core: 0 idle, 1 load plaintext, 2 load key, 3 encrypt.
- core_data_in  out  1  serial bit to core.
- core_debug  out  1  debug select; tied to 0 (ciphertext return).
- core_cipher_out  in  1  serial ciphertext bit from core.
- core_valid  in  1  qualifies core_cipher_out.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; busy 0, done 0, timeout 0.
  - ciphertext 0.
  - core_data_rdy 0, core_data_in 0, core_debug 0.
  - All counters 0.
- Reset mid-operation: next cycle is IDLE with core_data_rdy=0. The partial capture is discarded and ciphertext goes to 0.
- Bit order is LSB first for every phase. core_data_in is valid in the same cycle as the matching core_data_rdy code.
- States:
  - IDLE: core_data_rdy=0.
    - On start=1: latch plaintext, key and load_key into shift registers; clear timeout; go to LOAD_PT.
  - LOAD_PT: core_data_rdy=1, core_data_in=pt_shift[0], shift right each cycle.
    - Exactly BLOCK_W cycles.
    - Then go to LOAD_KEY if the latched load_key=1, else ENCRYPT.
  - LOAD_KEY: core_data_rdy=2, key bits LSB first.
    - Exactly KEY_W cycles, then ENCRYPT.
  - ENCRYPT: core_data_rdy=3, core_data_in=0. Held through capture.
    - Each cycle with core_valid=1: shift core_cipher_out into ct_shift at the MSB (LSB-first reassembly) and increment bit_cnt.
    - Cycles with core_valid=0 are gaps and are not sampled.
    - When bit_cnt reaches BLOCK_W: go to DONE.
  - DONE (one cycle): ciphertext<=ct_shift, done=1, core_data_rdy=0, busy drops to 0. Then IDLE.
- Latency with load_key=1: first core_data_rdy=1 appears 1 cycle after start. Encrypt starts BLOCK_W+KEY_W cycles later.
- Timeout:
  - wait_cnt counts ENCRYPT cycles without core_valid and resets on each sampled bit.
  - At wait_cnt==TIMEOUT_CYC-1 with no valid: set timeout=1, pulse done, leave ciphertext unchanged, core_data_rdy=0, return to IDLE.
- start while busy is ignored; there is no queueing.
- start in the same cycle as DONE is ignored. It is accepted in IDLE the next cycle.
- core_valid outside ENCRYPT is ignored.
- Counters are sized $clog2(max(BLOCK_W,KEY_W,TIMEOUT_CYC))+1 bits. No wrap is possible within a phase.

Test Plan:
- SIMON32/64 vector, load_key=1: key 0x1918111009080100, pt 0x65656877; core model returns 0xc69be9bb.
  - Required: 32 cycles rdy=1, then 64 cycles rdy=2, then rdy=3.
  - ciphertext=0xc69be9bb; done pulses exactly 1 cycle; busy low next cycle.
- Same pt with load_key=0 -> no rdy=2 cycles; rdy=3 begins exactly 32 cycles after the first rdy=1; same ciphertext.
- Core model inserts 5-cycle valid gaps between every 8 bits -> ciphertext still 0xc69be9bb, timeout=0.
- Core model never asserts valid, TIMEOUT_CYC=16 -> timeout=1 and done pulse 16 cycles after entering ENCRYPT; ciphertext unchanged; next start clears timeout.
- Assert reset during LOAD_KEY bit 20 -> next cycle core_data_rdy=0, busy=0, ciphertext=0; a fresh start then completes normally.
- start pulsed during LOAD_PT and in the DONE cycle -> both ignored; exactly one transaction and one done pulse observed.
